// File: rtl/vblank_write_scheduler_pkg.sv
// ============================================================================
// Module : wsched_pkg
// Shared types and constants for the vblank write scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package wsched_pkg;

  localparam int V_ACTIVE = 480;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } wsched_entry_t;

  typedef enum logic [1:0] {
    ACTIVE     = 2'd0,
    DRAIN      = 2'd1,
    IDLE_BLANK = 2'd2
  } wsched_state_t;

endpackage

`default_nettype wire

// File: rtl/vblank_write_scheduler_if.sv
// ============================================================================
// Module : vblank_write_scheduler_if
// Avalon-MM slave side and downstream register-port signals of the scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface vblank_write_scheduler_if;

  logic       AVL_READ;
  logic       AVL_WRITE;
  logic       AVL_CS;
  logic [6:0] AVL_ADDR;
  logic [7:0] AVL_WRITEDATA;
  logic       AVL_WAITREQUEST;
  logic       dn_cs;
  logic       dn_read;
  logic       dn_write;
  logic [6:0] dn_addr;
  logic [7:0] dn_writedata;

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
    output AVL_WAITREQUEST, dn_cs, dn_read, dn_write, dn_addr, dn_writedata
  );

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_WAITREQUEST, dn_cs, dn_read, dn_write, dn_addr, dn_writedata
  );

endinterface

`default_nettype wire

// File: rtl/vblank_write_scheduler_fifo.sv
// ============================================================================
// Module : wsched_fifo
// Power-of-2 FIFO of pending board writes; head entry readable combinationally.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module wsched_fifo
  import wsched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    i_push,
  input  wsched_entry_t           i_entry,
  input  logic                    i_pop,
  output wsched_entry_t           o_head,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int              c_aw      = $clog2(DEPTH);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
  localparam logic [c_aw:0]   c_cnt_one = (c_aw + 1)'(1);
  localparam logic [c_aw:0]   c_full    = (c_aw + 1)'(DEPTH);

  wsched_entry_t   r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == c_full);
  assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vblank_write_scheduler.sv
// ============================================================================
// Module : vblank_write_scheduler
// Holds CPU board writes until vertical blanking; mouse writes and reads bypass.
// Optional statistics ports when WSCHED_STATS_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vblank_write_scheduler
  import wsched_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int V_ACTIVE = wsched_pkg::V_ACTIVE
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  vblank_write_scheduler_if.slave  bus,
  input  logic [9:0]               DrawY,
  output logic                     commit_done
`ifdef WSCHED_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]   stat_hiwater,
  output logic [7:0]               stat_late
`endif
);

  localparam int         c_aw       = $clog2(DEPTH);
  localparam logic [9:0] c_v_active = 10'(V_ACTIVE);

  wsched_state_t r_state;
  logic          r_vblank;
  logic          r_vblank_d;

  logic          w_board_wr;
  logic          w_bypass;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  wsched_entry_t w_entry;
  wsched_entry_t w_head;
  logic [c_aw:0] w_count;
  logic [c_aw:0] w_count_next;

  assign w_board_wr = bus.AVL_CS & bus.AVL_WRITE & ~bus.AVL_ADDR[6];
  assign w_bypass   = bus.AVL_CS & (bus.AVL_READ | (bus.AVL_WRITE & bus.AVL_ADDR[6]));
  assign w_push     = w_board_wr & ~w_full;
  assign w_pop      = (r_state == DRAIN) & ~w_empty & ~w_bypass;
  assign w_entry    = '{addr: bus.AVL_ADDR[5:0], data: bus.AVL_WRITEDATA};
  assign w_count_next = w_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};

  assign bus.AVL_WAITREQUEST = w_full & w_board_wr;

  wsched_fifo #(
    .DEPTH   (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Bypass traffic owns the port; a drain pop simply waits a cycle.
  always_comb begin
    bus.dn_cs        = 1'b0;
    bus.dn_read      = 1'b0;
    bus.dn_write     = 1'b0;
    bus.dn_addr      = 7'd0;
    bus.dn_writedata = 8'd0;
    if (w_bypass) begin
      bus.dn_cs        = bus.AVL_CS;
      bus.dn_read      = bus.AVL_READ;
      bus.dn_write     = bus.AVL_WRITE;
      bus.dn_addr      = bus.AVL_ADDR;
      bus.dn_writedata = bus.AVL_WRITEDATA;
    end else if (w_pop) begin
      bus.dn_cs        = 1'b1;
      bus.dn_write     = 1'b1;
      bus.dn_addr      = {1'b0, w_head.addr};
      bus.dn_writedata = w_head.data;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ACTIVE;
      r_vblank    <= 1'b0;
      r_vblank_d  <= 1'b0;
      commit_done <= 1'b0;
    end else begin
      r_vblank    <= (DrawY >= c_v_active);
      r_vblank_d  <= r_vblank;
      commit_done <= 1'b0;
      case (r_state)
        ACTIVE: begin
          if (r_vblank && !r_vblank_d) r_state <= DRAIN;
        end
        DRAIN: begin
          if (!r_vblank) begin
            r_state <= ACTIVE;
          end else if (w_count_next == '0) begin
            // Entering with nothing queued is not a commit, so only pulse on a pop.
            r_state     <= IDLE_BLANK;
            commit_done <= w_pop;
          end
        end
        IDLE_BLANK: begin
          if (!r_vblank)     r_state <= ACTIVE;
          else if (!w_empty) r_state <= DRAIN;
        end
        default: r_state <= ACTIVE;
      endcase
    end
  end

`ifdef WSCHED_STATS_EN
  logic [c_aw:0] r_hiwater;
  logic [7:0]    r_late;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_hiwater <= '0;
      r_late    <= 8'd0;
    end else begin
      if (w_count > r_hiwater) r_hiwater <= w_count;
      if ((r_state == DRAIN) && !r_vblank && (w_count_next != '0) && (r_late != 8'hFF))
        r_late <= r_late + 8'd1;
    end
  end

  assign stat_hiwater = r_hiwater;
  assign stat_late    = r_late;
`endif

endmodule

`default_nettype wire
